gcd_engine: RTL and testbench
=============================

# gcd_engine

Parametrised, self-timed GCD engine that replaces the split datapath and controller pair feeding the binary-to-BCD display path. It takes two W-bit operands on a single-cycle `go` pulse and iterates internally. It supports two algorithms, selected per operation: subtractive (Euclid) and binary (Stein). It returns the result with a one-cycle `done` pulse, a `busy` level and a cycle count for on-board benchmarking of the two modes.

## Interface
- `W`, default 8: operand and result width; must be at least 2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `clr`  in  1: asynchronous, active-high reset.
- `go`  in  1: start request, sampled on `clk`; ignored while `busy`=1.
- `mode`  in  1: 0 selects subtractive, 1 selects binary (Stein); sampled with `go`.
- `a`  in  W: operand A; sampled with `go`.
- `b`  in  W: operand B; sampled with `go`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: one-cycle pulse when `gcd`, `cycles` and `zero` update.
- `gcd`  out  W: result register; holds its value until the next `done`.
- `cycles`  out  W+1: number of RUN cycles the last operation took; saturates at all-ones.
- `zero`  out  1: last operation had a=b=0, so the result is undefined and reported as 0.

## Operation
- Two states: IDLE and RUN.
- Internal registers: x and y (W bits), k (shift count, clog2(W)+1 bits), md (latched mode), and a cycle counter.
- **IDLE, go=1:** load x←a, y←b, k←0, md←mode, counter←0, then go to RUN.
- **RUN:** evaluate one step per cycle and increment the counter, saturating. The first matching rule wins:
  1. x=0 and y=0: result 0, zero=1, finish.
  2. x=0: result y, finish.
  3. y=0: result x, finish.
  4. x=y: result x<<k, finish. In subtract mode k stays 0.
  5. Stein only, x and y both even: x←x>>1, y←y>>1, k←k+1.
  6. Stein only, x even: x←x>>1.
  7. Stein only, y even: y←y>>1.
  8. x>y: x←x−y; otherwise y←y−x.
- **Finish:** in the same edge, register `gcd`, `zero` and `cycles` (including the finishing cycle), pulse `done` and return to IDLE.
- **Arithmetic:** subtraction is unsigned W-bit and never underflows, because the larger operand is always the minuend. x<<k never overflows, since the true GCD fits in W bits.
- **go while busy:** ignored, with no queueing. go in the cycle where `done`=1 is accepted, because the state is already IDLE.
- **clr at any time, including mid-RUN:** state←IDLE; busy, done, zero, gcd, cycles, x, y and k all ←0. The operation in flight is discarded.

## Timing
- go is sampled at edge E0. Rule evaluations occur at E1..EN, where N = final `cycles`.
- `busy` is 1 from after E0 through EN, and 0 after EN.
- `done` is 1 for exactly the one cycle after EN.
- `gcd`, `cycles` and `zero` change only at EN or on clr.
- Best case: N=1, for any zero operand or a=b.
- Worst case: subtract mode gives N=2^W−1 (for example a=2^W−1, b=1). Stein mode is bounded by 4W.
- Reset values: busy=0, done=0, gcd=0, cycles=0, zero=0.

## Structure
- Package `gcd_pkg`:
  - state enum (IDLE, RUN)
  - mode constants MODE_SUB=1'b0 and MODE_BIN=1'b1
  - a function for the k width, clog2(W)+1
- Sub-module `gcd_step`: purely combinational, one rule evaluation.
  - Inputs: x, y, k, md.
  - Outputs: next x, next y, next k, fin, result, zero flag.
- `gcd_engine` itself holds only the registers, the FSM and the saturating counter.
- The existing `binary2bcd` and `sevenseg` consume `gcd` unchanged when W=8.

## Test plan
- **Subtract, 12/18:** W=8, mode=0, a=12, b=18, go pulse → steps y=6, x=6, then equal. Required: gcd=6, cycles=3, done exactly 1 cycle, busy for 3 cycles.
- **Stein, 12/18:** mode=1, a=12, b=18 → steps (6,9,k=1), (3,9), (3,6), (3,3). Required: gcd=6, cycles=5.
- **Zero operands, both modes:**
  - a=0, b=7 → gcd=7, cycles=1, zero=0.
  - a=0, b=0 → gcd=0, zero=1, cycles=1.
  - a=9, b=9 → gcd=9, cycles=1.
- **Worst-case subtract:** a=255, b=1, mode=0 → gcd=1, cycles=255. The same operands with mode=1 → gcd=1, cycles≤32.
- **go while busy:** second go with new operands 2 cycles into the 255/1 run → ignored, result still 1. go in the `done` cycle with a=8, b=12 → accepted, gcd=4.
- **Reset mid-operation:** clr asserted asynchronously mid-RUN, between edges → all outputs 0 immediately. After release, a fresh go with a=21, b=14 → gcd=7, with no residue from the aborted operation.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine: FSM state encoding,
// algorithm-select values and the shift-count width helper.
package gcd_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_BIN = 1'b1;

   function automatic int unsigned k_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD rule evaluation. Covers both the subtractive
// (Euclid) and the binary (Stein) algorithm; the first matching rule wins.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int unsigned W  = 8,
   parameter int unsigned KW = k_width(W)
) (
   input  logic [W-1:0]  x,
   input  logic [W-1:0]  y,
   input  logic [KW-1:0] k,
   input  logic          md,
   output logic [W-1:0]  nx,
   output logic [W-1:0]  ny,
   output logic [KW-1:0] nk,
   output logic          fin,
   output logic [W-1:0]  res,
   output logic          zf
);

   logic bin;
   assign bin = (md == MODE_BIN);

   always_comb begin
      nx  = x;
      ny  = y;
      nk  = k;
      fin = 1'b0;
      res = '0;
      zf  = 1'b0;
      if (x == '0 && y == '0) begin
         fin = 1'b1;
         zf  = 1'b1;
      end else if (x == '0) begin
         fin = 1'b1;
         res = y;
      end else if (y == '0) begin
         fin = 1'b1;
         res = x;
      end else if (x == y) begin
         // k only ever advances in Stein mode, so this is a plain copy for Euclid
         fin = 1'b1;
         res = x << k;
      end else if (bin && !x[0] && !y[0]) begin
         nx = x >> 1;
         ny = y >> 1;
         nk = k + 1'b1;
      end else if (bin && !x[0]) begin
         nx = x >> 1;
      end else if (bin && !y[0]) begin
         ny = y >> 1;
      end else if (x > y) begin
         nx = x - y;
      end else begin
         ny = y - x;
      end
   end

endmodule

// File: rtl/gcd_engine.sv
// Self-timed GCD engine: operand/state registers, IDLE/RUN control and a
// saturating RUN-cycle counter around one gcd_step evaluation per clock.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         go,
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] gcd,
   output logic [W:0]   cycles,
   output logic         zero
);

   localparam int unsigned KW = k_width(W);

   state_t        state;
   logic [W-1:0]  x, y, nx, ny, res;
   logic [KW-1:0] k, nk;
   logic          md, fin, zf;
   logic [W:0]    cnt, cnt_inc;

   gcd_step #(.W(W), .KW(KW)) u_step (
      .x   (x),
      .y   (y),
      .k   (k),
      .md  (md),
      .nx  (nx),
      .ny  (ny),
      .nk  (nk),
      .fin (fin),
      .res (res),
      .zf  (zf)
   );

   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
   assign busy    = (state == RUN);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         x      <= '0;
         y      <= '0;
         k      <= '0;
         md     <= MODE_SUB;
         cnt    <= '0;
         done   <= 1'b0;
         gcd    <= '0;
         cycles <= '0;
         zero   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  x     <= a;
                  y     <= b;
                  k     <= '0;
                  md    <= mode;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               cnt <= cnt_inc;
               if (fin) begin
                  // reported count includes this finishing evaluation
                  gcd    <= res;
                  zero   <= zf;
                  cycles <= cnt_inc;
                  done   <= 1'b1;
                  state  <= IDLE;
               end else begin
                  x <= nx;
                  y <= ny;
                  k <= nk;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed self-checking bench for gcd_engine (W=8): both algorithms,
// zero/equal operands, worst case, go-while-busy and mid-run reset.
module tb_gcd_engine;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       go = 1'b0;
   logic       mode = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy, done, zero;
   logic [7:0] gcd;
   logic [8:0] cycles;

   int n_tests = 0;
   int n_fail  = 0;

   gcd_engine #(.W(8)) dut (
      .clk    (clk),
      .clr    (clr),
      .go     (go),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .gcd    (gcd),
      .cycles (cycles),
      .zero   (zero)
   );

   always #5 clk = ~clk;

   // Drive a one-cycle go; returns at the first negedge after the sampling edge.
   task automatic start_op(input logic m, input logic [7:0] aa, input logic [7:0] bb);
      @(negedge clk);
      mode = m; a = aa; b = bb; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   // Waits (bounded) for done, counting negedges with busy high.
   task automatic wait_done(output int bcnt, output bit to);
      bcnt = 0;
      to   = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (done) begin
            to = 1'b0;
            break;
         end
         if (busy) bcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #3;
      n_tests++;
      if ({busy, done, zero, gcd, cycles} !== 20'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%b done=%b zero=%b gcd=%0d cycles=%0d want all 0",
                  busy, done, zero, gcd, cycles);
      end
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_sub_12_18;
      int bc; bit to;
      start_op(1'b0, 8'd12, 8'd18);
      wait_done(bc, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL sub12_18_timeout got no done want done"); end
      n_tests++;
      if (gcd !== 8'd6) begin n_fail++; $display("FAIL sub12_18_gcd got %0d want 6", gcd); end
      n_tests++;
      if (cycles !== 9'd3) begin n_fail++; $display("FAIL sub12_18_cycles got %0d want 3", cycles); end
      n_tests++;
      if (bc !== 3) begin n_fail++; $display("FAIL sub12_18_busy_len got %0d want 3", bc); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL sub12_18_busy_at_done got %b want 0", busy); end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL sub12_18_done_width got %b want 0", done); end
   endtask

   task automatic test_stein_12_18;
      int bc; bit to;
      start_op(1'b1, 8'd12, 8'd18);
      wait_done(bc, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL bin12_18_timeout got no done want done"); end
      n_tests++;
      if (gcd !== 8'd6) begin n_fail++; $display("FAIL bin12_18_gcd got %0d want 6", gcd); end
      n_tests++;
      if (cycles !== 9'd5) begin n_fail++; $display("FAIL bin12_18_cycles got %0d want 5", cycles); end
      n_tests++;
      if (bc !== 5) begin n_fail++; $display("FAIL bin12_18_busy_len got %0d want 5", bc); end
   endtask

   task automatic test_zero_ops;
      logic [7:0] ta [3] = '{8'd0, 8'd0, 8'd9};
      logic [7:0] tb [3] = '{8'd7, 8'd0, 8'd9};
      logic [7:0] tg [3] = '{8'd7, 8'd0, 8'd9};
      logic       tz [3] = '{1'b0, 1'b1, 1'b0};
      int bc; bit to;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 3; i++) begin
            start_op(m[0], ta[i], tb[i]);
            wait_done(bc, to);
            n_tests++;
            if (to || gcd !== tg[i] || cycles !== 9'd1 || zero !== tz[i]) begin
               n_fail++;
               $display("FAIL zero_ops m=%0d a=%0d b=%0d got gcd=%0d cyc=%0d zero=%b to=%b want gcd=%0d cyc=1 zero=%b",
                        m, ta[i], tb[i], gcd, cycles, zero, to, tg[i], tz[i]);
            end
         end
      end
   endtask

   task automatic test_worst_case;
      int bc; bit to;
      start_op(1'b0, 8'd255, 8'd1);
      wait_done(bc, to);
      n_tests++;
      if (to || gcd !== 8'd1 || cycles !== 9'd255) begin
         n_fail++;
         $display("FAIL worst_sub got gcd=%0d cyc=%0d to=%b want gcd=1 cyc=255", gcd, cycles, to);
      end
      start_op(1'b1, 8'd255, 8'd1);
      wait_done(bc, to);
      n_tests++;
      if (to || gcd !== 8'd1 || cycles !== 9'd15) begin
         n_fail++;
         $display("FAIL worst_bin got gcd=%0d cyc=%0d to=%b want gcd=1 cyc=15", gcd, cycles, to);
      end
   endtask

   task automatic test_go_while_busy;
      int bc; bit to;
      start_op(1'b0, 8'd255, 8'd1);
      @(negedge clk);
      mode = 1'b0; a = 8'd8; b = 8'd12; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_done(bc, to);
      n_tests++;
      if (to || gcd !== 8'd1 || cycles !== 9'd255) begin
         n_fail++;
         $display("FAIL go_busy_ignored got gcd=%0d cyc=%0d to=%b want gcd=1 cyc=255", gcd, cycles, to);
      end
      // go presented in the done cycle itself must be taken
      mode = 1'b0; a = 8'd8; b = 8'd12; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL go_in_done_busy got %b want 1", busy); end
      wait_done(bc, to);
      n_tests++;
      if (to || gcd !== 8'd4 || cycles !== 9'd3) begin
         n_fail++;
         $display("FAIL go_in_done_result got gcd=%0d cyc=%0d to=%b want gcd=4 cyc=3", gcd, cycles, to);
      end
   endtask

   task automatic test_clr_mid_run;
      int bc; bit to;
      start_op(1'b0, 8'd255, 8'd1);
      repeat (4) @(negedge clk);
      #2 clr = 1'b1;
      #1;
      n_tests++;
      if ({busy, done, zero, gcd, cycles} !== 20'd0) begin
         n_fail++;
         $display("FAIL clr_async got busy=%b done=%b zero=%b gcd=%0d cycles=%0d want all 0",
                  busy, done, zero, gcd, cycles);
      end
      @(negedge clk);
      clr = 1'b0;
      start_op(1'b0, 8'd21, 8'd14);
      wait_done(bc, to);
      n_tests++;
      if (to || gcd !== 8'd7 || cycles !== 9'd3 || zero !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_fresh_op got gcd=%0d cyc=%0d zero=%b to=%b want gcd=7 cyc=3 zero=0",
                  gcd, cycles, zero, to);
      end
   endtask

   initial begin
      test_reset();
      test_sub_12_18();
      test_stein_12_18();
      test_zero_ops();
      test_worst_case();
      test_go_while_busy();
      test_clr_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
